// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
// Holds the arbiter state encoding and the grant-index width helper.
package axis_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // A single-bit index is still needed when only one or two sources exist.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_select.sv
// Combinational round-robin selector: rotate the request vector so the search
// starts at last_grant+1, priority-encode the lowest set bit, then un-rotate.
module rr_select #(
   parameter int NUM_S = 4,
   parameter int SEL_W = 2
) (
   input  logic [NUM_S-1:0] req_i,
   input  logic [SEL_W-1:0] last_grant_i,
   output logic             any_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [SEL_W:0]   start;
   logic [SEL_W:0]   offset;
   logic [SEL_W:0]   sum;
   logic [NUM_S-1:0] rot;

   always_comb begin
      start = {1'b0, last_grant_i} + (SEL_W+1)'(1);
      if (start >= (SEL_W+1)'(NUM_S)) begin
         start = '0;
      end
      rot = NUM_S'({req_i, req_i} >> start);
      offset = '0;
      // Descending scan so the lowest rotated position wins.
      for (int k = NUM_S - 1; k >= 0; k--) begin
         if (rot[k]) begin
            offset = (SEL_W+1)'(k);
         end
      end
      sum = start + offset;
      if (sum >= (SEL_W+1)'(NUM_S)) begin
         sum = sum - (SEL_W+1)'(NUM_S);
      end
      idx_o = sum[SEL_W-1:0];
      any_o = |req_i;
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant locked for a whole packet,
// followed by one registered output stage tagging each beat with its source id.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_S      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1,
   parameter int SEL_W      = clog2_min1(NUM_S)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_S*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_S*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [NUM_S*USER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_S-1:0]            s_axis_tlast,
   input  logic [NUM_S-1:0]            s_axis_tvalid,
   output logic [NUM_S-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
   output logic [USER_WIDTH-1:0]       m_axis_tuser,
   output logic [SEL_W-1:0]            m_axis_tid,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        grant_valid,
   output logic [SEL_W-1:0]            grant_idx
);

   arb_state_e            state_q, state_d;
   logic [SEL_W-1:0]      grant_idx_q, grant_idx_d;
   logic [SEL_W-1:0]      last_grant_q, last_grant_d;
   logic                  grant_valid_q, grant_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
   logic [USER_WIDTH-1:0] m_user_q, m_user_d;
   logic [SEL_W-1:0]      m_tid_q, m_tid_d;
   logic                  m_last_q, m_last_d;
   logic                  m_valid_q, m_valid_d;

   logic                  rr_any;
   logic [SEL_W-1:0]      rr_idx;
   logic                  out_free;
   logic                  load;
   logic                  sel_valid, sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [KEEP_WIDTH-1:0] sel_keep;
   logic [USER_WIDTH-1:0] sel_user;

   rr_select #(
      .NUM_S(NUM_S),
      .SEL_W(SEL_W)
   ) u_rr_select (
      .req_i       (s_axis_tvalid),
      .last_grant_i(last_grant_q),
      .any_o       (rr_any),
      .idx_o       (rr_idx)
   );

   // Granted-source mux and slave-side handshake.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_user  = '0;
      for (int i = 0; i < NUM_S; i++) begin
         if (grant_idx_q == SEL_W'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
         end
      end
      // The output register can accept a beat when empty or draining this cycle.
      out_free = !m_valid_q || m_axis_tready;
      load     = (state_q == BUSY) && out_free && sel_valid;
      s_axis_tready = '0;
      if (state_q == BUSY) begin
         s_axis_tready[grant_idx_q] = out_free;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      last_grant_d  = last_grant_q;
      m_data_d      = m_data_q;
      m_keep_d      = m_keep_q;
      m_user_d      = m_user_q;
      m_tid_d       = m_tid_q;
      m_last_d      = m_last_q;
      m_valid_d     = m_valid_q;

      case (state_q)
         IDLE: begin
            if (rr_any) begin
               grant_idx_d   = rr_idx;
               grant_valid_d = 1'b1;
               state_d       = BUSY;
            end
         end
         BUSY: begin
            if (load && sel_last) begin
               last_grant_d  = grant_idx_q;
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new load overrides the downstream drain so beats stream back to back.
      if (load) begin
         m_data_d  = sel_data;
         m_keep_d  = sel_keep;
         m_user_d  = sel_user;
         m_last_d  = sel_last;
         m_tid_d   = grant_idx_q;
         m_valid_d = 1'b1;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         last_grant_q  <= SEL_W'(NUM_S - 1);
         m_data_q      <= '0;
         m_keep_q      <= '0;
         m_user_q      <= '0;
         m_tid_q       <= '0;
         m_last_q      <= 1'b0;
         m_valid_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         last_grant_q  <= last_grant_d;
         m_data_q      <= m_data_d;
         m_keep_q      <= m_keep_d;
         m_user_q      <= m_user_d;
         m_tid_q       <= m_tid_d;
         m_last_q      <= m_last_d;
         m_valid_q     <= m_valid_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tuser  = m_user_q;
   assign m_axis_tid    = m_tid_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tvalid = m_valid_q;
   assign grant_valid   = grant_valid_q;
   assign grant_idx     = grant_idx_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: per-source beat queues drive the
// slaves, a scoreboard of expected output beats is checked at the master port.
module tb_axis_packet_arbiter;

   localparam int NUM_S = 4;
   localparam int DW    = 32;
   localparam int KW    = DW / 8;
   localparam int UW    = 1;
   localparam int SW    = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } src_beat_t;

   typedef struct packed {
      logic [SW-1:0] tid;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } exp_t;

   typedef struct {
      int         prime;
      logic [3:0] req;
      int         exp_first;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_S*DW-1:0]   s_axis_tdata = '0;
   logic [NUM_S*KW-1:0]   s_axis_tkeep = '0;
   logic [NUM_S*UW-1:0]   s_axis_tuser = '0;
   logic [NUM_S-1:0]      s_axis_tlast = '0;
   logic [NUM_S-1:0]      s_axis_tvalid;
   logic [NUM_S-1:0]      s_axis_tready;
   logic [DW-1:0]         m_axis_tdata;
   logic [KW-1:0]         m_axis_tkeep;
   logic [UW-1:0]         m_axis_tuser;
   logic [SW-1:0]         m_axis_tid;
   logic                  m_axis_tlast;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready = 1'b1;
   logic                  grant_valid;
   logic [SW-1:0]         grant_idx;

   logic [NUM_S-1:0]      drv_valid = '0;
   logic [NUM_S-1:0]      hold = '0;
   assign s_axis_tvalid = drv_valid & ~hold;

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   axis_packet_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tkeep (s_axis_tkeep),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tid   (m_axis_tid),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx)
   );

   int        n_checks = 0;
   int        n_fail = 0;
   exp_t      exp_q[$];
   int        out_cyc_q[$];
   src_beat_t src_q[NUM_S][$];
   exp_t      mon_act;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // scoreboard: every downstream handshake pops one expected beat
   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready) begin
         mon_act = {m_axis_tid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         out_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat: got unexpected 0x%0h, expected none (cycle %0d)", mon_act, cyc);
         end else begin
            chk("beat", 64'(mon_act), 64'(exp_q.pop_front()));
         end
      end
   end

   // slave drivers: present queue heads, advance on an accepted handshake
   initial begin
      logic [NUM_S-1:0] acc;
      forever begin
         @(negedge clk);
         acc = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_S; i++) begin
            if (acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_q[i].size() > 0) begin
               drv_valid[i]              = 1'b1;
               s_axis_tdata[i*DW +: DW]  = src_q[i][0].data;
               s_axis_tkeep[i*KW +: KW]  = src_q[i][0].keep;
               s_axis_tuser[i*UW +: UW]  = src_q[i][0].user;
               s_axis_tlast[i]           = src_q[i][0].last;
            end else begin
               drv_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic send_pkt(input int src, input int n, input logic [DW-1:0] base);
      src_beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data = base + DW'(k);
         b.keep = KW'($urandom_range(1, 15));
         b.user = UW'($urandom_range(0, 1));
         b.last = (k == n - 1);
         src_q[src].push_back(b);
         exp_q.push_back({SW'(src), b.data, b.keep, b.user, b.last});
      end
   endtask

   function automatic bit tb_idle();
      bit r;
      r = (exp_q.size() == 0) && !m_axis_tvalid;
      for (int i = 0; i < NUM_S; i++) if (src_q[i].size() > 0) r = 1'b0;
      return r;
   endfunction

   task automatic flush_all();
      exp_q.delete();
      for (int i = 0; i < NUM_S; i++) src_q[i].delete();
   endtask

   task automatic wait_drain(input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tb_idle()) break;
      end
      if (i == budget) begin
         timeout_fail(name);
         flush_all();
      end
   endtask

   task automatic wait_grant(input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (grant_valid) break;
      end
      if (i == budget) timeout_fail(name);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      flush_all();
      hold = '0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[8];
      int         t_v;
      int         n_held;
      int         last;
      int         i;
      logic [3:0] pat;
      logic [3:0] done;

      vecs[0] = '{-1, 4'b1111, 0};
      vecs[1] = '{-1, 4'b0100, 2};
      vecs[2] = '{ 3, 4'b1001, 0};
      vecs[3] = '{ 1, 4'b0011, 0};
      vecs[4] = '{ 2, 4'b1101, 3};
      vecs[5] = '{ 0, 4'b0001, 0};
      vecs[6] = '{ 1, 4'b0110, 2};
      vecs[7] = '{ 3, 4'b1000, 3};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_m_data", 64'(m_axis_tdata), 64'd0);
      chk("rst_m_tid", 64'(m_axis_tid), 64'd0);
      chk("rst_m_last", 64'(m_axis_tlast), 64'd0);
      chk("rst_grant_valid", 64'(grant_valid), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
      chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
      rst = 1'b0;

      // 3-beat packet from src0: latency and back-to-back beats
      out_cyc_q.delete();
      send_pkt(0, 3, 32'hA0);
      t_v = -1;
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         if (s_axis_tvalid[0]) begin
            t_v = cyc;
            break;
         end
      end
      wait_drain(50, "t1_drain");
      chk("t1_nbeats", 64'(out_cyc_q.size()), 64'd3);
      if (out_cyc_q.size() == 3) begin
         chk("t1_latency", 64'(out_cyc_q[0] - t_v), 64'd2);
         chk("t1_gap1", 64'(out_cyc_q[1] - out_cyc_q[0]), 64'd1);
         chk("t1_gap2", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd1);
      end

      // all four sources with 2-beat packets: 0,1,2,3,0 and one dead cycle
      do_reset();
      out_cyc_q.delete();
      send_pkt(0, 2, 32'h100);
      send_pkt(1, 2, 32'h110);
      send_pkt(2, 2, 32'h120);
      send_pkt(3, 2, 32'h130);
      send_pkt(0, 2, 32'h140);
      wait_drain(100, "t2_drain");
      chk("t2_nbeats", 64'(out_cyc_q.size()), 64'd10);
      if (out_cyc_q.size() == 10) begin
         for (int k = 1; k < 10; k++)
            chk("t2_spacing", 64'(out_cyc_q[k] - out_cyc_q[k-1]), (k % 2 == 1) ? 64'd1 : 64'd2);
      end

      // downstream backpressure 1,0,0,1 during a 4-beat src2 packet
      do_reset();
      pat = 4'b1001;
      n_held = 0;
      send_pkt(2, 4, 32'hC0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         m_axis_tready = pat[k % 4];
         @(negedge clk);
         if (m_axis_tvalid && !m_axis_tready) begin
            n_held++;
            chk("t3_hold_ready", 64'(s_axis_tready[2]), 64'd0);
         end
      end
      @(posedge clk);
      #1;
      m_axis_tready = 1'b1;
      wait_drain(50, "t3_drain");
      chk("t3_held_seen", 64'(n_held > 0), 64'd1);

      // src1 stalls mid-packet while src3 waits
      do_reset();
      send_pkt(1, 4, 32'h210);
      send_pkt(3, 2, 32'h230);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (src_q[1].size() <= 3) break;
      end
      if (i == 20) timeout_fail("t4_first_beat");
      @(posedge clk);
      #2;
      hold[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_ready3", 64'(s_axis_tready[3]), 64'd0);
         chk("t4_grant", 64'(grant_idx), 64'd1);
      end
      @(posedge clk);
      #2;
      hold[1] = 1'b0;
      wait_drain(60, "t4_drain");
      chk("t4_grant_after", 64'(grant_idx), 64'd3);

      // single-beat packets from src3 only
      do_reset();
      out_cyc_q.delete();
      for (int k = 0; k < 4; k++) send_pkt(3, 1, 32'h350 + DW'(k));
      wait_drain(60, "t5_drain");
      chk("t5_nbeats", 64'(out_cyc_q.size()), 64'd4);
      if (out_cyc_q.size() == 4) begin
         for (int k = 1; k < 4; k++)
            chk("t5_period", 64'(out_cyc_q[k] - out_cyc_q[k-1]), 64'd2);
      end
      chk("t5_grant", 64'(grant_idx), 64'd3);

      // reset in the middle of a src0 packet
      do_reset();
      out_cyc_q.delete();
      send_pkt(0, 4, 32'h4D0);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_cyc_q.size() >= 1) break;
      end
      if (i == 20) timeout_fail("t6_first_beat");
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_m_valid", 64'(m_axis_tvalid), 64'd0);
      chk("t6_m_data", 64'(m_axis_tdata), 64'd0);
      chk("t6_m_keep", 64'(m_axis_tkeep), 64'd0);
      chk("t6_m_user", 64'(m_axis_tuser), 64'd0);
      chk("t6_m_last", 64'(m_axis_tlast), 64'd0);
      chk("t6_m_tid", 64'(m_axis_tid), 64'd0);
      chk("t6_grant_valid", 64'(grant_valid), 64'd0);
      chk("t6_grant_idx", 64'(grant_idx), 64'd0);
      chk("t6_s_ready", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
      flush_all();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      send_pkt(1, 2, 32'h4E0);
      wait_grant(20, "t6_grant_wait");
      chk("t6_regrant", 64'(grant_idx), 64'd1);
      wait_drain(40, "t6_drain");

      // arbitration table: prime the pointer, then present a request mask
      for (int v = 0; v < 8; v++) begin
         do_reset();
         last = NUM_S - 1;
         if (vecs[v].prime >= 0) begin
            send_pkt(vecs[v].prime, 1, 32'h5000 + DW'(v));
            wait_drain(40, "tbl_prime");
            last = vecs[v].prime;
         end
         done = '0;
         for (int n = 0; n < NUM_S; n++) begin
            for (int k = 1; k <= NUM_S; k++) begin
               int c;
               c = (last + k) % NUM_S;
               if (vecs[v].req[c] && !done[c]) begin
                  send_pkt(c, 2, 32'h6000 + DW'(v * 16 + c));
                  done[c] = 1'b1;
                  last = c;
                  break;
               end
            end
         end
         wait_grant(20, "tbl_grant_wait");
         chk("tbl_first_grant", 64'(grant_idx), 64'(vecs[v].exp_first));
         wait_drain(100, "tbl_drain");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
